// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants, dispatch op_class encodings and the
// dispatch queue FSM state encoding.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd15
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } dq_state_e;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational register-field and op_class decode of one instruction word.
module instr_field_decode
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] instr,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [3:0]            op_class,
  output logic                  illegal
);

  // funct3 and the upper immediate bits play no part in this decode
  logic unused_bits;
  assign unused_bits = ^{instr[DATA_WIDTH-1:25], instr[14:12]};

  assign rd  = instr[11:7];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  always_comb begin
    op_class = CLS_ILLEGAL;
    illegal  = 1'b0;
    case (instr[6:0])
      OPC_OP:     op_class = CLS_ALU_R;
      OPC_OP_IMM: op_class = CLS_ALU_I;
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_STORE:  op_class = CLS_STORE;
      OPC_BRANCH: op_class = CLS_BRANCH;
      OPC_JAL:    op_class = CLS_JAL;
      OPC_JALR:   op_class = CLS_JALR;
      OPC_LUI:    op_class = CLS_LUI;
      OPC_AUIPC:  op_class = CLS_AUIPC;
      default: begin
        op_class = CLS_ILLEGAL;
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dispatch_queue.sv
// Fetch-to-dispatch instruction queue: circular FIFO of {instruction, pc}
// with a redirect FSM and a head-entry decoder.
//
// state    | meaning
// ST_IDLE  | one cycle after reset release, no fetch
// ST_RUN   | normal push/pop
// ST_FLUSH | redirect in progress; fetch held off, queue shown empty
module dispatch_queue
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      instruction,
  input  logic [DATA_WIDTH-1:0]      pc_in,
  input  logic                       flush,
  output logic                       fetch_rd_en,
  input  logic                       dispatch_ready,
  output logic                       dispatch_valid,
  output logic [DATA_WIDTH-1:0]      dispatch_instruction,
  output logic [DATA_WIDTH-1:0]      dispatch_pc,
  output logic [4:0]                 rd,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [3:0]                 op_class,
  output logic                       illegal,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  dq_state_e             state_q, state_d;
  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];

  logic full, empty, push, pop;
  logic [3:0] dec_class;
  logic       dec_illegal;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign fetch_rd_en    = (state_q == ST_RUN) && !full && !flush;
  assign dispatch_valid = !empty && (state_q != ST_FLUSH);

  assign push = fetch_rd_en;
  assign pop  = dispatch_valid && dispatch_ready && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   if (flush) state_d = ST_FLUSH;
      ST_FLUSH: if (!flush) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + PW'(1);
        if (pop)  head_q <= head_q + PW'(1);
        if (push && !pop)      count_q <= count_q + CW'(1);
        else if (pop && !push) count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[tail_q] <= instruction;
      pc_mem_q[tail_q]    <= pc_in;
    end
  end

  assign dispatch_instruction = instr_mem_q[head_q];
  assign dispatch_pc          = pc_mem_q[head_q];
  assign occupancy            = count_q;

  instr_field_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .instr    (dispatch_instruction),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .op_class (dec_class),
    .illegal  (dec_illegal)
  );

  // Zeroed storage decodes as illegal; mask the class when nothing is presented
  // so an empty or reset queue drives all-zero outputs.
  assign op_class = dispatch_valid ? dec_class : 4'd0;
  assign illegal  = dispatch_valid & dec_illegal;

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: queue-based reference model,
// decode vector table, directed corner sequences and random traffic.
module tb_dispatch_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] instruction = '0;
  logic [DW-1:0] pc_in = '0;
  logic          flush = 1'b0;
  logic          dispatch_ready = 1'b0;
  logic          fetch_rd_en, dispatch_valid, illegal;
  logic [DW-1:0] dispatch_instruction, dispatch_pc;
  logic [4:0]    rd, rs1, rs2;
  logic [3:0]    op_class;
  logic [2:0]    occupancy;

  dispatch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instruction          (instruction),
    .pc_in                (pc_in),
    .flush                (flush),
    .fetch_rd_en          (fetch_rd_en),
    .dispatch_ready       (dispatch_ready),
    .dispatch_valid       (dispatch_valid),
    .dispatch_instruction (dispatch_instruction),
    .dispatch_pc          (dispatch_pc),
    .rd                   (rd),
    .rs1                  (rs1),
    .rs2                  (rs2),
    .op_class             (op_class),
    .illegal              (illegal),
    .occupancy            (occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of accepted entries plus two phase flags.
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];
  bit   started = 0;
  bit   in_flush = 0;

  logic [6:0] opc_tab [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  function automatic logic [3:0] ref_class(input logic [31:0] w);
    for (int i = 0; i < 9; i++)
      if (w[6:0] == opc_tab[i]) return 4'(i);
    return 4'd15;
  endfunction

  // Called at posedge+1 with inputs set; compares at posedge+4, advances the
  // model on the edge, returns at the next posedge+1.
  task automatic tick();
    bit fe, v;
    ent_t h;
    #3;
    fe = started && !in_flush && (q.size() < DEPTH) && !flush;
    v  = (q.size() > 0) && !in_flush;
    chk("fetch_rd_en", fetch_rd_en, fe);
    chk("dispatch_valid", dispatch_valid, v);
    chk("occupancy", occupancy, q.size());
    if (v) begin
      h = q[0];
      chk("head_instr", dispatch_instruction, h.ins);
      chk("head_pc", dispatch_pc, h.pc);
      chk("head_class", op_class, ref_class(h.ins));
      chk("head_illegal", illegal, ref_class(h.ins) == 4'd15);
      chk("head_rd", rd, h.ins[11:7]);
      chk("head_rs1", rs1, h.ins[19:15]);
      chk("head_rs2", rs2, h.ins[24:20]);
    end
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (v && dispatch_ready) void'(q.pop_front());
      if (fe) q.push_back(ent_t'{ins: instruction, pc: pc_in});
    end
    if (!started) begin
      started  = 1;
      in_flush = 0;
    end else in_flush = flush;
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q.delete();
    started  = 0;
    in_flush = 0;
    #2;
    chk("rst_fetch_rd_en", fetch_rd_en, 0);
    chk("rst_valid", dispatch_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_instr", dispatch_instruction, 0);
    chk("rst_pc", dispatch_pc, 0);
    chk("rst_rd", rd, 0);
    chk("rst_rs1", rs1, 0);
    chk("rst_rs2", rs2, 0);
    chk("rst_class", op_class, 0);
    chk("rst_illegal", illegal, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  cls;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;
  vec_t vecs[12];

  logic [31:0] fill_seq [5];

  initial begin
    vecs[0]  = vec_t'{32'h00208133, 4'd0,  1'b0, 5'd2,  5'd1,  5'd2};
    vecs[1]  = vec_t'{32'h00500093, 4'd1,  1'b0, 5'd1,  5'd0,  5'd5};
    vecs[2]  = vec_t'{32'h00F88F83, 4'd2,  1'b0, 5'd31, 5'd17, 5'd15};
    vecs[3]  = vec_t'{32'h00000023, 4'd3,  1'b0, 5'd0,  5'd0,  5'd0};
    vecs[4]  = vec_t'{32'h00000063, 4'd4,  1'b0, 5'd0,  5'd0,  5'd0};
    vecs[5]  = vec_t'{32'h0000006F, 4'd5,  1'b0, 5'd0,  5'd0,  5'd0};
    vecs[6]  = vec_t'{32'h00000067, 4'd6,  1'b0, 5'd0,  5'd0,  5'd0};
    vecs[7]  = vec_t'{32'h00000037, 4'd7,  1'b0, 5'd0,  5'd0,  5'd0};
    vecs[8]  = vec_t'{32'h00000017, 4'd8,  1'b0, 5'd0,  5'd0,  5'd0};
    vecs[9]  = vec_t'{32'h0000007B, 4'd15, 1'b1, 5'd0,  5'd0,  5'd0};
    vecs[10] = vec_t'{32'h00000000, 4'd15, 1'b1, 5'd0,  5'd0,  5'd0};
    vecs[11] = vec_t'{32'hFFFFFFFF, 4'd15, 1'b1, 5'd31, 5'd31, 5'd31};

    fill_seq = '{32'h00500093, 32'h00208133, 32'h00F88F83, 32'h00000037, 32'h00000017};

    @(posedge clk);
    #1;
    do_reset();

    // Fill to full with dispatch stalled; IDLE cycle first.
    dispatch_ready = 1'b0;
    instruction = fill_seq[0];
    pc_in = 32'h1000;
    tick();
    for (int i = 0; i < 5; i++) begin
      instruction = fill_seq[i];
      pc_in = 32'h1000 + 32'(i * 4);
      tick();
      chk("occ_climb", occupancy, (i + 1 > 4) ? 4 : i + 1);
    end
    chk("full_no_fetch", fetch_rd_en, 0);

    // Drain from full: ADDI then ADD.
    dispatch_ready = 1'b1;
    chk("pop0_class", op_class, 1);
    chk("pop0_rd", rd, 1);
    tick();
    chk("pop1_class", op_class, 0);
    chk("pop1_rd", rd, 2);
    for (int i = 0; i < 3; i++) tick();

    // Flush at occupancy 2 with dispatch_ready high.
    do_flush();
    dispatch_ready = 1'b0;
    instruction = 32'h00000037;
    pc_in = 32'h2000;
    tick();
    pc_in = 32'h2004;
    tick();
    chk("pre_flush_occ", occupancy, 2);
    flush = 1'b1;
    dispatch_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_occ", occupancy, 0);
    chk("flush_state_fetch", fetch_rd_en, 0);
    tick();
    chk("post_flush_fetch", fetch_rd_en, 1);

    // Streaming at occupancy 1 across pointer wrap.
    do_flush();
    dispatch_ready = 1'b0;
    instruction = 32'h00208133;
    pc_in = 32'd100;
    tick();
    dispatch_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      pc_in = 32'(100 + k);
      chk("stream_pc", dispatch_pc, 32'(100 + k - 1));
      chk("stream_occ", occupancy, 1);
      tick();
    end

    // Decode table, each entry presented at the head of a freshly flushed queue.
    for (int i = 0; i < 12; i++) begin
      do_flush();
      dispatch_ready = 1'b0;
      instruction = vecs[i].ins;
      pc_in = 32'(i);
      tick();
      chk("tbl_class", op_class, vecs[i].cls);
      chk("tbl_illegal", illegal, vecs[i].ill);
      chk("tbl_rd", rd, vecs[i].rd);
      chk("tbl_rs1", rs1, vecs[i].rs1);
      chk("tbl_rs2", rs2, vecs[i].rs2);
    end

    // Reset with an illegal entry at the head and a non-empty queue.
    tick();
    do_reset();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      dispatch_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) instruction = $urandom;
      else instruction = {25'($urandom), opc_tab[$urandom_range(0, 8)]};
      pc_in = $urandom;
      tick();
      if (c == 200) begin
        flush = 1'b0;
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the instruction and PC width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; it is a power of two.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock, and all state updates occur on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port instruction SHALL be an input, DATA_WIDTH bits wide: the instruction word from fetch, valid in any cycle fetch_rd_en=1.
REQ-006 Port pc_in SHALL be an input, DATA_WIDTH bits wide: the PC of that instruction word.
REQ-007 Port flush SHALL be an input, 1 bit wide: branch/jump redirect, tied to the same jump_branch_valid that drives fetch.
REQ-008 Port fetch_rd_en SHALL be an output, 1 bit wide: the Read_enable to fetch, and it also serves as the push strobe.
REQ-009 Port dispatch_ready SHALL be an input, 1 bit wide: the downstream accepts the head entry.
REQ-010 Port dispatch_valid SHALL be an output, 1 bit wide: the head entry is present.
REQ-011 Ports dispatch_instruction and dispatch_pc SHALL be outputs, DATA_WIDTH bits each: the head entry.
REQ-012 Ports rd, rs1 and rs2 SHALL be outputs, 5 bits each: the register fields [11:7], [19:15] and [24:20] of the head.
REQ-013 Port op_class SHALL be an output, 4 bits wide: the decoded class of the head (see REQ-022).
REQ-014 Port illegal SHALL be an output, 1 bit wide: the head opcode is not in the class table.
REQ-015 Port occupancy SHALL be an output, log2(DEPTH)+1 bits wide: the current entry count.

Function
REQ-016 FSM states SHALL be IDLE, RUN and FLUSH.
- IDLE→RUN always, one cycle after reset release.
- RUN→FLUSH on flush=1.
- FLUSH→RUN when flush=0, else it stays in FLUSH.
REQ-017 fetch_rd_en SHALL equal (state==RUN) && !full && !flush, which is combinational from registered state and count plus flush.
REQ-018 A push SHALL write {instruction, pc_in} at the tail pointer in the cycle fetch_rd_en=1; the entry becomes visible at the head no earlier than the next cycle.
REQ-019 A pop SHALL occur when dispatch_valid && dispatch_ready; the head pointer advances at the clock edge.
REQ-020 A simultaneous push and pop SHALL leave occupancy unchanged.
- At full, no push occurs even if a pop occurs in the same cycle, because full is taken from the registered count.
REQ-021 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
- full = (count==DEPTH); empty = (count==0).
- dispatch_valid = !empty && state!=FLUSH.
REQ-022 op_class SHALL decode instruction[6:0] as follows:
- 0110011=0 (ALU R-type)
- 0010011=1 (ALU immediate)
- 0000011=2 (LOAD)
- 0100011=3 (STORE)
- 1100011=4 (BRANCH)
- 1101111=5 (JAL)
- 1100111=6 (JALR)
- 0110111=7 (LUI)
- 0010111=8 (AUIPC)
- anything else gives op_class=15 and illegal=1.
REQ-023 When empty, the decode outputs and dispatch_* values SHALL be don't-care, but they SHALL NOT be X in simulation; storage is reset to 0.
REQ-024 On flush=1, head, tail and count SHALL clear to 0 at the next edge, and any pop in that cycle SHALL be ignored.
- A flush has priority over a push and a pop in the same cycle.
REQ-025 The FLUSH state SHALL hold fetch_rd_en=0 for exactly one cycle after flush deasserts, covering fetch's redirected first read; back-to-back flushes extend FLUSH.

Reset
REQ-026 When reset=0, the block SHALL asynchronously force the following:
- state=IDLE, head=tail=count=0
- all storage to 0
- fetch_rd_en=0, dispatch_valid=0, occupancy=0
REQ-027 Assertion of reset mid-operation SHALL discard all entries without issuing any pop; the first push SHALL occur no earlier than the second rising edge after reset deasserts.

Structure
REQ-028 The op_class encodings, the RISC-V opcode constants and the FSM state encodings SHALL live in the shared package riscv_pkg.
REQ-029 The field and class decode SHALL be one combinational sub-module, instr_field_decode, instantiated on the head entry; the FIFO and FSM SHALL stay in dispatch_queue.

Verification
REQ-030 Release reset with dispatch_ready=0 and drive 5 instructions → IDLE lasts one cycle, occupancy climbs 1..4, fetch_rd_en=0 once occupancy=4, and the 5th instruction is not written.
REQ-031 From full with dispatch_ready=1 held, pop instructions 0x00500093 (ADDI) and 0x00208133 (ADD) → op_class=1 then 0, rd=1 then 2, and pops continue in push order.
REQ-032 With occupancy 2, assert flush for 1 cycle together with dispatch_ready=1 → occupancy=0 next cycle, no pop credited, and fetch_rd_en=0 for the flush cycle plus one FLUSH cycle, then 1.
REQ-033 Run continuous push and pop at occupancy 1 for 10 cycles, across pointer wrap → occupancy stays 1, and dispatch_pc increments by 1 per cycle in order.
REQ-034 Push 0xFFFFFFFF → op_class=15 and illegal=1 at the head; assert reset mid-stream → all outputs are 0 asynchronously, before the next edge.
